// File: rtl/dti_tniu_async_noc_writer_pkg.sv
// Shared types, field positions and Johnson-pointer helpers for the DTI
// request async-FIFO writer.
package dti_tniu_async_noc_writer_pkg;

    localparam int DTI_GNPD_PLD_WIDTH     = 104;
    localparam int DTI_GNPD_PAYLOAD_WIDTH = 90;
    localparam int DTI_GNPD_ID_WIDTH      = 6;

    localparam int DTI_GNPD_LAST_LSB    = 0;
    localparam int DTI_GNPD_QOS_LSB     = 1;
    localparam int DTI_GNPD_TGTID_LSB   = 2;
    localparam int DTI_GNPD_SRCID_LSB   = 8;
    localparam int DTI_GNPD_PAYLOAD_LSB = 14;

    // Helpers work on a fixed-width container; depths up to this value are supported.
    localparam int DTI_AFIFO_MAX_DEPTH = 64;
    localparam int JOHNSON_BIT_W       = $clog2(DTI_AFIFO_MAX_DEPTH);

    typedef logic [DTI_AFIFO_MAX_DEPTH-1:0] johnson_t;

    // Field order matches the stored word: payload on top, last at bit 0.
    typedef struct packed {
        logic [DTI_GNPD_PAYLOAD_WIDTH-1:0] payload;
        logic [DTI_GNPD_ID_WIDTH-1:0]      srcid;
        logic [DTI_GNPD_ID_WIDTH-1:0]      tgtid;
        logic                              qos;
        logic                              last;
    } gnpd_word_t;

    // Shift left by one, feeding the inverted top bit of an n-bit code into bit 0.
    function automatic johnson_t johnson_next(input johnson_t cur, input int unsigned n);
        johnson_t nxt;
        nxt = '0;
        for (int unsigned i = 1; i < DTI_AFIFO_MAX_DEPTH; i++) begin
            if (i < n) begin
                nxt[JOHNSON_BIT_W'(i)] = cur[JOHNSON_BIT_W'(i - 1)];
            end
        end
        nxt[0] = ~cur[JOHNSON_BIT_W'(n - 1)];
        return nxt;
    endfunction

    // Storage slot for an n-bit Johnson code; any bit pattern maps into 0..n-1.
    function automatic int unsigned johnson_idx(input johnson_t cur, input int unsigned n);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < DTI_AFIFO_MAX_DEPTH; i++) begin
            if ((i < n) && cur[JOHNSON_BIT_W'(i)]) begin
                ones++;
            end
        end
        if (cur[JOHNSON_BIT_W'(n - 1)]) begin
            return n - ones;
        end
        return ones;
    endfunction

endpackage

// File: rtl/dti_afifo_ptr_sync.sv
// Two-flop synchronizer for a Johnson pointer crossing into the clk domain.
module dti_afifo_ptr_sync #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the pointer through both stages, or zero them for a low-power clear.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        if (sync_clear) begin
            meta_d = '0;
            sync_d = '0;
        end
    end

    // Synchronizer stages, zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dti_tniu_async_noc_writer.sv
// NoC-side write endpoint of the DTI request async FIFO: packs flits into
// local storage, publishes a Johnson write pointer and serves the reader mux.
module dti_tniu_async_noc_writer
    import dti_tniu_async_noc_writer_pkg::*;
#(
    parameter int ASYNC_FIFO_DEPTH = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    input  logic [DTI_GNPD_PAYLOAD_WIDTH-1:0]   req_payload,
    input  logic [DTI_GNPD_ID_WIDTH-1:0]        req_srcid,
    input  logic [DTI_GNPD_ID_WIDTH-1:0]        req_tgtid,
    input  logic                                req_qos,
    input  logic                                req_last,
    output logic                                req_ready,
    output logic [ASYNC_FIFO_DEPTH-1:0]         wptr_async,
    input  logic [ASYNC_FIFO_DEPTH-1:0]         rptr_async,
    input  logic [ASYNC_FIFO_DEPTH-1:0]         rptr_sync,
    output logic [DTI_GNPD_PLD_WIDTH:0]         pld_sync,
    input  logic                                stall,
    input  logic                                clear,
    output logic                                full_zero
);

    localparam int unsigned N     = ASYNC_FIFO_DEPTH;
    localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     wptr_q, wptr_d;
    logic [N-1:0]     rptr_s;
    gnpd_word_t       mem_q [N];
    gnpd_word_t       mem_d [N];
    logic             full_zero_q, full_zero_d;
    logic             empty, full, write_en, clear_go;
    logic [IDX_W-1:0] widx, ridx;
    gnpd_word_t       wr_word, rd_word;

    dti_afifo_ptr_sync #(
        .WIDTH(ASYNC_FIFO_DEPTH)
    ) u_rptr_sync (
        .clk       (clk),
        .rst       (rst),
        .sync_clear(clear_go),
        .d         (rptr_async),
        .q         (rptr_s)
    );

    // Occupancy flags, handshake, slot selection and the reader-facing mux.
    always_comb begin
        empty     = (wptr_q == rptr_s);
        full      = (wptr_q == ~rptr_s);
        clear_go  = clear && stall && empty;
        req_ready = !full && !stall && !clear;
        write_en  = req_valid && req_ready;
        widx      = IDX_W'(johnson_idx(johnson_t'(wptr_q), N));
        ridx      = IDX_W'(johnson_idx(johnson_t'(rptr_sync), N));
        wr_word.payload = req_payload;
        wr_word.srcid   = req_srcid;
        wr_word.tgtid   = req_tgtid;
        wr_word.qos     = req_qos;
        wr_word.last    = req_last;
        rd_word   = mem_q[ridx];
        pld_sync  = {^rd_word, rd_word};
    end

    // Entry and pointer move on the same edge; a drained LP clear rewinds the pointer.
    always_comb begin
        wptr_d      = wptr_q;
        mem_d       = mem_q;
        full_zero_d = empty;
        if (clear_go) begin
            wptr_d = '0;
        end else if (write_en) begin
            mem_d[widx] = wr_word;
            wptr_d      = N'(johnson_next(johnson_t'(wptr_q), N));
        end
    end

    // Pointer, storage and empty-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            full_zero_q <= 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q      <= wptr_d;
            full_zero_q <= full_zero_d;
            mem_q       <= mem_d;
        end
    end

    assign wptr_async = wptr_q;
    assign full_zero  = full_zero_q;

endmodule
